// File: rtl/dstack_ctrl.sv
// Data-stack controller for the Forth core: T is held here, N and below live in an external stack memory.
// One op per accepted request; ROT takes two cycles with op_ready low in the second. stk_* are combinational.
module dstack_ctrl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int DB = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tos,
    output logic [DB-1:0]    depth,
    output logic             ovf,
    output logic             unf,
    output logic             stk_we,
    output logic [1:0]       stk_delta,
    output logic [WIDTH-1:0] stk_wd,
    input  logic [WIDTH-1:0] stk_rd1,
    input  logic [WIDTH-1:0] stk_rd2
);

    localparam logic [3:0] OP_LIT   = 4'h1, OP_DUP  = 4'h2, OP_DROP = 4'h3, OP_SWAP = 4'h4;
    localparam logic [3:0] OP_OVER  = 4'h5, OP_NIP  = 4'h6, OP_ROT  = 4'h7, OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB   = 4'h9, OP_AND  = 4'hA, OP_OR   = 4'hB, OP_XOR  = 4'hC;
    localparam logic [3:0] OP_INV   = 4'hD, OP_2DROP = 4'hE;

    localparam logic [1:0] D_HOLD = 2'b00, D_PUSH = 2'b01, D_POP1 = 2'b11, D_POP2 = 2'b10;

    localparam logic signed [DB+1:0] MAX_DEPTH = (DB + 2)'(DEPTH + 1);
    localparam logic [DB-1:0]        FULL      = DB'(DEPTH + 1);

    typedef enum logic {S_IDLE, S_ROT2} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       rot_t;
    logic                   accept;
    logic [WIDTH-1:0]       t_next;
    logic                   we;
    logic [1:0]             delta;
    logic [WIDTH-1:0]       wd;
    logic [DB-1:0]          need;
    logic signed [2:0]      dd;
    logic signed [DB+1:0]   dsum;
    logic                   ovf_new;
    logic                   unf_new;
    logic [DB-1:0]          depth_next;

    assign accept = op_valid && op_ready;

    always_comb begin
        t_next = tos;
        we     = 1'b0;
        delta  = D_HOLD;
        wd     = tos;
        need   = '0;
        dd     = 3'sd0;
        if (state == S_ROT2) begin
            // Second half of ROT: push the old T (c) back under the new top.
            we    = 1'b1;
            delta = D_PUSH;
            wd    = rot_t;
        end else if (accept) begin
            case (op)
                OP_LIT:   begin t_next = din; we = 1'b1; delta = D_PUSH; dd = 3'sd1; end
                OP_DUP:   begin we = 1'b1; delta = D_PUSH; need = DB'(1); dd = 3'sd1; end
                OP_DROP:  begin t_next = stk_rd1; delta = D_POP1; need = DB'(1); dd = -3'sd1; end
                OP_SWAP:  begin t_next = stk_rd1; we = 1'b1; need = DB'(2); end
                OP_OVER:  begin t_next = stk_rd1; we = 1'b1; delta = D_PUSH; need = DB'(2); dd = 3'sd1; end
                OP_NIP:   begin delta = D_POP1; need = DB'(2); dd = -3'sd1; end
                OP_ROT:   begin t_next = stk_rd2; we = 1'b1; delta = D_POP1; wd = stk_rd1; need = DB'(3); end
                OP_ADD:   begin t_next = stk_rd1 + tos; delta = D_POP1; need = DB'(2); dd = -3'sd1; end
                OP_SUB:   begin t_next = stk_rd1 - tos; delta = D_POP1; need = DB'(2); dd = -3'sd1; end
                OP_AND:   begin t_next = stk_rd1 & tos; delta = D_POP1; need = DB'(2); dd = -3'sd1; end
                OP_OR:    begin t_next = stk_rd1 | tos; delta = D_POP1; need = DB'(2); dd = -3'sd1; end
                OP_XOR:   begin t_next = stk_rd1 ^ tos; delta = D_POP1; need = DB'(2); dd = -3'sd1; end
                OP_INV:   begin t_next = ~tos; need = DB'(1); end
                OP_2DROP: begin t_next = stk_rd2; delta = D_POP2; need = DB'(2); dd = -3'sd2; end
                default:  begin end
            endcase
        end
    end

    assign stk_we    = we;
    assign stk_delta = delta;
    assign stk_wd    = wd;

    // Depth arithmetic in a signed, two-bit-wider domain so both clamps are visible.
    assign dsum    = $signed({2'b00, depth}) + $signed({{(DB - 1){dd[2]}}, dd});
    assign ovf_new = accept && (dsum > MAX_DEPTH);
    assign unf_new = accept && (depth < need);

    always_comb begin
        if (dsum[DB+1])
            depth_next = '0;
        else if (dsum > MAX_DEPTH)
            depth_next = FULL;
        else
            depth_next = dsum[DB-1:0];
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state    <= S_IDLE;
            op_ready <= 1'b1;
            tos      <= '0;
            depth    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            rot_t    <= '0;
        end else begin
            ovf <= (ovf && !clr_err) || ovf_new;
            unf <= (unf && !clr_err) || unf_new;
            if (state == S_ROT2) begin
                state    <= S_IDLE;
                op_ready <= 1'b1;
            end else if (accept) begin
                tos   <= t_next;
                depth <= depth_next;
                if (op == OP_ROT) begin
                    state    <= S_ROT2;
                    op_ready <= 1'b0;
                    rot_t    <= tos;
                end
            end
        end
    end

endmodule
